// File: rtl/shift8_seq_ctrl_pkg.sv
// Shared encodings for the 8-bit shifter sequencer and the counter blocks.
// Opcodes and state codes are fixed 2-bit values so other blocks can decode them directly.
package shift8_seq_ctrl_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/shift8_seq_ctrl_dp.sv
// Shifter datapath: WIDTH-bit register with load / single-bit shift next-value mux.
// Holds its value whenever neither load nor shift_en is asserted.
module shift8_dp
  import shift8_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] sop,
                                                  input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (sop)
      OP_LSL:  shift_step = {v[WIDTH-2:0], 1'b0};
      OP_LSR:  shift_step = {1'b0, v[WIDTH-1:1]};
      OP_ASR:  shift_step = sv >>> 1;
      default: shift_step = {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    q_nxt = q;
    if (load)
      q_nxt = d_in;
    else if (shift_en)
      q_nxt = shift_step(op, q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/shift8_seq_ctrl.sv
// Start/busy/done sequencer that applies one shift command one bit per clock.
// FSM and down-counter live here; the register and shift mux live in shift8_dp.
module shift8_seq_ctrl
  import shift8_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic             load;
  logic             shift_en;

  assign load     = (state == S_IDLE) && start;
  assign shift_en = (state == S_SHIFT);

  // busy/done are registered alongside the state so they decode from it alone
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= OP_LSL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op;
            cnt  <= amt;
            busy <= 1'b1;
            if (amt != '0) begin
              state <= S_SHIFT;
              done  <= 1'b0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  shift8_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .op       (op_r),
    .d_in     (d_in),
    .q        (q)
  );

endmodule

// File: tb/tb_shift8_seq_ctrl.sv
// Directed bench for shift8_seq_ctrl: reset, each opcode, amt=0, ignored starts,
// continuous start, and reset in the middle of a command.
module tb_shift8_seq_ctrl;
  import shift8_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] amt;
  logic [7:0] d_in;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  shift8_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .d_in    (d_in),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until done (current cycle counts as 1); bounded.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 40) begin
      tick();
      c++;
    end
  endtask

  // Issue one command and verify latency, busy, result and post-done hold.
  task automatic run_cmd(input string tag, input logic [1:0] o, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] exp_q);
    int c;
    start = 1'b1; op = o; amt = a; d_in = d;
    tick();
    start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 8'h00;
    wait_done(1, c);
    check({tag, "_lat"}, c, a + 1);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_q"}, q, exp_q);
    tick();
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    tick();
    tick();
    check({tag, "_hold_q"}, q, exp_q);
  endtask

  initial begin
    int c;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 8'h00;
    tick();
    tick();
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset_n = 1'b1;
    tick();
    check("idle_q", q, 8'h00);

    run_cmd("lsl3", OP_LSL, 3'd3, 8'h96, 8'hB0);
    run_cmd("asr2", OP_ASR, 3'd2, 8'h90, 8'hE4);
    run_cmd("lsr7", OP_LSR, 3'd7, 8'hF0, 8'h01);
    run_cmd("ror1", OP_ROR, 3'd1, 8'h81, 8'hC0);
    run_cmd("amt0", OP_LSL, 3'd0, 8'h5A, 8'h5A);
    run_cmd("ror5", OP_ROR, 3'd5, 8'h13, 8'h98);

    // Start pulse while shifting must be ignored.
    start = 1'b1; op = OP_LSL; amt = 3'd5; d_in = 8'h03;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = OP_ROR; amt = 3'd1; d_in = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(3, c);
    check("ign_lat", c, 6);
    check("ign_q", q, 8'h60);
    tick();
    tick();
    check("ign_idle_busy", busy, 1'b0);

    // Start held high: one command per amt+2 cycles.
    start = 1'b1; op = OP_LSL; amt = 3'd2; d_in = 8'h01;
    tick();
    wait_done(1, c);
    check("cont_lat", c, 3);
    check("cont_q0", q, 8'h04);
    for (int k = 0; k < 2; k++) begin
      tick();
      wait_done(1, c);
      check("cont_period", c, 4);
      check("cont_q", q, 8'h04);
    end
    start = 1'b0;
    tick();
    tick();
    check("cont_end_busy", busy, 1'b0);

    // Reset in cycle 2 of a 6-step command.
    start = 1'b1; op = OP_LSL; amt = 3'd6; d_in = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    reset_n = 1'b1;
    c = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) c++;
    end
    check("mid_rst_nodone", c, 0);
    check("mid_rst_hold_q", q, 8'h00);
    run_cmd("post_rst", OP_ASR, 3'd3, 8'h40, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
